// File: rtl/dma_pkg.sv
// Shared types and AHB-Lite constants for the DMA transfer controller.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_D,
    ST_WR_A,
    ST_WR_D,
    ST_FIN
  } dma_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

endpackage

// File: rtl/dma_xfer_ctrl_if.sv
// AHB-Lite master-side bus bundle (request/grant plus address and data phases).
interface dma_xfer_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              hbusreq;
  logic              hgrant;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hbusreq, haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hgrant, hready, hresp, hrdata
  );

  modport slave (
    input  hbusreq, haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hgrant, hready, hresp, hrdata
  );

endinterface

// File: rtl/dma_xfer_ctrl.sv
// Word-by-word DMA copy engine: single AHB read into a holding buffer, then single write.
// Optional macro DMA_ERR_ABORT_EN: ERROR response in a data phase sets err and aborts to FIN.
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] src_addr_reg,
  input  logic [ADDR_W-1:0] dest_addr_reg,
  input  logic [LEN_W-1:0]  transfer_length_reg,
  output logic              busy,
  output logic              done,
  output logic              err,
  dma_xfer_ctrl_if.master   ahb
);

`ifdef DMA_ERR_ABORT_EN
  localparam bit ERR_ABORT = 1'b1;
`else
  localparam bit ERR_ABORT = 1'b0;
`endif

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              err_q, err_d;
  logic              resp_err;

  // An error response is honoured on any data-phase cycle, including the first (hready low) cycle.
  assign resp_err = ERR_ABORT && (ahb.hresp == HRESP_ERROR);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      remain_q <= '0;
      buf_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      remain_q <= remain_d;
      buf_q    <= buf_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    remain_d    = remain_q;
    buf_d       = buf_q;
    err_d       = err_q;
    ahb.hbusreq = 1'b0;
    ahb.haddr   = '0;
    ahb.htrans  = HTRANS_IDLE;
    ahb.hwrite  = 1'b0;
    ahb.hsize   = HSIZE_WORD;
    ahb.hburst  = HBURST_SINGLE;
    ahb.hwdata  = buf_q;
    done        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (dma_start) begin
          rd_ptr_d = src_addr_reg;
          wr_ptr_d = dest_addr_reg;
          remain_d = transfer_length_reg;
          err_d    = 1'b0;
          state_d  = (transfer_length_reg == '0) ? ST_FIN : ST_RD_A;
        end
      end
      ST_RD_A: begin
        ahb.hbusreq = 1'b1;
        ahb.haddr   = rd_ptr_q;
        if (ahb.hgrant) ahb.htrans = HTRANS_NONSEQ;
        if (ahb.hgrant && ahb.hready) state_d = ST_RD_D;
      end
      ST_RD_D: begin
        ahb.hbusreq = 1'b1;
        ahb.haddr   = rd_ptr_q;
        if (resp_err) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (ahb.hready) begin
          buf_d   = ahb.hrdata;
          state_d = ST_WR_A;
        end
      end
      ST_WR_A: begin
        ahb.hbusreq = 1'b1;
        ahb.haddr   = wr_ptr_q;
        ahb.hwrite  = 1'b1;
        if (ahb.hgrant) ahb.htrans = HTRANS_NONSEQ;
        if (ahb.hgrant && ahb.hready) state_d = ST_WR_D;
      end
      ST_WR_D: begin
        ahb.hbusreq = 1'b1;
        ahb.haddr   = wr_ptr_q;
        if (resp_err) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (ahb.hready) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(4);
          wr_ptr_d = wr_ptr_q + ADDR_W'(4);
          remain_d = remain_q - LEN_W'(1);
          state_d  = (remain_q == LEN_W'(1)) ? ST_FIN : ST_RD_A;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign err  = err_q & ERR_ABORT;

endmodule
